// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ controller: icodes, status codes and
// the sequencer state encoding.
package y86_pkg;

  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STAT_W  = 3;

  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  localparam logic [STAT_W-1:0] SAOK = 3'd1;
  localparam logic [STAT_W-1:0] SHLT = 3'd2;
  localparam logic [STAT_W-1:0] SADR = 3'd3;
  localparam logic [STAT_W-1:0] SINS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALTED    = 3'd7
  } state_t;

  // A state that is stepping an instruction (counts toward cycles and busy).
  function automatic logic is_active(input state_t s);
    return (s != S_IDLE) && (s != S_HALTED);
  endfunction

endpackage

// File: rtl/seq_stage_need.sv
// Per-icode stage requirements; the same table drives decode register selects.
module seq_stage_need
  import y86_pkg::*;
(
  input  logic [ICODE_W-1:0] icode,
  output logic               needs_mem,
  output logic               mem_write,
  output logic               needs_wb
);

  always_comb begin
    needs_mem = 1'b0;
    mem_write = 1'b0;
    needs_wb  = 1'b0;
    case (icode)
      IRMMOVQ: begin
        needs_mem = 1'b1;
        mem_write = 1'b1;
      end
      IMRMOVQ, IRET, IPOPQ: begin
        needs_mem = 1'b1;
        needs_wb  = 1'b1;
      end
      // call/push write memory and also update %rsp in writeback
      ICALL, IPUSHQ: begin
        needs_mem = 1'b1;
        mem_write = 1'b1;
        needs_wb  = 1'b1;
      end
      IRRMOVQ, IIRMOVQ, IOPQ: begin
        needs_wb = 1'b1;
      end
      default: begin
        needs_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle SEQ Y86-64 controller: steps each instruction through its needed
// stages, runs imem/dmem handshakes, and owns stat and the retire/cycle counters.
module seq_stage_sequencer
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_ack,
  input  logic             imem_err,
  input  logic             dmem_ack,
  input  logic             dmem_err,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_wr,
  output logic             f_en,
  output logic             d_en,
  output logic             e_en,
  output logic             m_en,
  output logic             w_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  state_t               state_q, state_d;
  logic [ICODE_W-1:0]   icode_q, icode_d;
  logic [STAT_W-1:0]    stat_q, stat_d;
  logic [CNT_W-1:0]     retired_q, retired_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic                 imem_req_q, imem_req_d;
  logic                 dmem_req_q, dmem_req_d;
  logic                 dmem_wr_q, dmem_wr_d;
  logic                 f_en_q, f_en_d;
  logic                 d_en_q, d_en_d;
  logic                 e_en_q, e_en_d;
  logic                 m_en_q, m_en_d;
  logic                 w_en_q, w_en_d;
  logic                 pc_en_q, pc_en_d;
  logic                 busy_q, busy_d;

  logic                 needs_mem;
  logic                 mem_write;
  logic                 needs_wb;

  // Requirements come from the latched icode; it is only consulted after DECODE.
  seq_stage_need u_need (
    .icode     (icode_q),
    .needs_mem (needs_mem),
    .mem_write (mem_write),
    .needs_wb  (needs_wb)
  );

  // Next-state, status, counters and icode latch.
  always_comb begin
    state_d   = state_q;
    icode_d   = icode_q;
    stat_d    = stat_q;
    retired_d = retired_q + CNT_W'(state_q == S_PCUPD);
    cycles_d  = cycles_q + CNT_W'(is_active(state_q));

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          if (imem_err) begin
            stat_d  = SADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        icode_d = icode;
        if (!instr_valid) begin
          stat_d  = SINS;
          state_d = S_HALTED;
        end else if (icode == IHALT) begin
          stat_d  = SHLT;
          state_d = S_HALTED;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (needs_mem)     state_d = S_MEMORY;
        else if (needs_wb) state_d = S_WRITEBACK;
        else               state_d = S_PCUPD;
      end
      S_MEMORY: begin
        if (dmem_ack) begin
          if (dmem_err) begin
            stat_d  = SADR;
            state_d = S_HALTED;
          end else if (needs_wb) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_PCUPD;
          end
        end
      end
      S_WRITEBACK: begin
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so the registered copies track state_q.
  always_comb begin
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_wr_d  = 1'b0;
    f_en_d     = 1'b0;
    d_en_d     = 1'b0;
    e_en_d     = 1'b0;
    m_en_d     = 1'b0;
    w_en_d     = 1'b0;
    pc_en_d    = 1'b0;
    busy_d     = is_active(state_d);

    case (state_d)
      S_FETCH: begin
        imem_req_d = 1'b1;
        f_en_d     = 1'b1;
      end
      S_DECODE:  d_en_d = 1'b1;
      S_EXECUTE: e_en_d = 1'b1;
      S_MEMORY: begin
        dmem_req_d = 1'b1;
        m_en_d     = 1'b1;
        dmem_wr_d  = mem_write;
      end
      S_WRITEBACK: w_en_d  = 1'b1;
      S_PCUPD:     pc_en_d = 1'b1;
      default: begin
        busy_d = is_active(state_d);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      icode_q    <= IHALT;
      stat_q     <= SAOK;
      retired_q  <= '0;
      cycles_q   <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_wr_q  <= 1'b0;
      f_en_q     <= 1'b0;
      d_en_q     <= 1'b0;
      e_en_q     <= 1'b0;
      m_en_q     <= 1'b0;
      w_en_q     <= 1'b0;
      pc_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      icode_q    <= icode_d;
      stat_q     <= stat_d;
      retired_q  <= retired_d;
      cycles_q   <= cycles_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_wr_q  <= dmem_wr_d;
      f_en_q     <= f_en_d;
      d_en_q     <= d_en_d;
      e_en_q     <= e_en_d;
      m_en_q     <= m_en_d;
      w_en_q     <= w_en_d;
      pc_en_q    <= pc_en_d;
      busy_q     <= busy_d;
    end
  end

  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dmem_wr  = dmem_wr_q;
  assign f_en     = f_en_q;
  assign d_en     = d_en_q;
  assign e_en     = e_en_q;
  assign m_en     = m_en_q;
  assign w_en     = w_en_q;
  assign pc_en    = pc_en_q;
  assign stat     = stat_q;
  assign busy     = busy_q;
  assign retired  = retired_q;
  assign cycles   = cycles_q;

endmodule
